ps2_scan_sequencer: RTL

Sits between ps2_keyboard's byte FIFO (ready/nextdata_n/data/overflow) and consumers such as the seven-segment display, key2ascii and counters. Pops raw scan-code bytes one at a time, assembles E0/F0 prefixed sequences into single key events, and filters typematic repeats. Tracks shift/caps-lock state and presents each event on a valid/ready output handshake. It is the single owner of nextdata_n.

---
 rtl/ps2_scan_sequencer_pkg.sv | 34 +++
 rtl/ps2_scan_sequencer_if.sv | 35 +++
 rtl/ps2_scan_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared constants and types for the PS/2 scan-code sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scan-code constants, FSM state encoding, held-key type and a
// helper that flags byte values that never occur as a legal scan code.
package ps2_scan_sequencer_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2,
    S_EMIT = 2'd3
  } state_e;

  // Key identity used for repeat detection: the E0 prefix distinguishes
  // e.g. keypad arrows from their non-extended twins.
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_t;

  // Pause (E1) is not assembled, and 00/FF are keyboard error/overrun codes.
  function automatic logic is_bad_byte(input logic [7:0] b);
    return (b == SC_PAUSE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_if.sv
// Bundle of the FIFO-side pop interface and the key-event output handshake.
// Latency: n/a (wiring only).
// Backpressure: evt_valid/evt_ready; FIFO side is a level ready plus an active-low pop.
// Ports: master = sequencer (drives ps2_nextdata_n and evt_*/trackers),
//        slave  = FIFO + consumer side (drives ps2_ready/data/overflow, evt_ready).
interface ps2_scan_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             ps2_ready;
  logic [7:0]       ps2_data;
  logic             ps2_overflow;
  logic             ps2_nextdata_n;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic             evt_repeat;
  logic             shift_held;
  logic             caps_lock;
  logic [CNT_W-1:0] key_count;
  logic             err;

  modport master (
    input  ps2_ready, ps2_data, ps2_overflow, evt_ready,
    output ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
           shift_held, caps_lock, key_count, err
  );

  modport slave (
    output ps2_ready, ps2_data, ps2_overflow, evt_ready,
    input  ps2_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_repeat,
           shift_held, caps_lock, key_count, err
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// Pops scan-code bytes, folds E0/F0 prefixes into key events, tracks shift/caps/held key.
// Latency: event valid 2 cycles after the pop is issued; prefix bytes cost 3 cycles each.
// Backpressure: while an event waits for evt_ready no further pops are issued.
// Ports: clk, rst (async, active-high); bus (master modport) carries the FIFO
//        pop interface, the event handshake and the shift/caps/count/err trackers.
module ps2_scan_sequencer
  import ps2_scan_sequencer_pkg::*;
#(
  parameter int REPEAT_FILTER = 1,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_scan_sequencer_if.master bus
);

  state_e           state_q;
  logic [7:0]       byte_q;
  logic             ext_q, brk_q;
  logic             nd_n_q;
  logic             vld_q;
  logic [7:0]       code_q;
  logic             evt_ext_q, evt_brk_q;
  key_t             held_q;
  logic             held_v_q;
  logic             lsh_q, rsh_q, caps_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  key_t evt_key;
  logic is_rep;

  assign evt_key = key_t'({evt_ext_q, code_q});
  // Only a make can be a repeat; vld_q is high exactly while in S_EMIT.
  assign is_rep  = vld_q && !evt_brk_q && (REPEAT_FILTER != 0) &&
                   held_v_q && (held_q == evt_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      nd_n_q    <= 1'b1;
      vld_q     <= 1'b0;
      code_q    <= 8'h00;
      evt_ext_q <= 1'b0;
      evt_brk_q <= 1'b0;
      held_q    <= '0;
      held_v_q  <= 1'b0;
      lsh_q     <= 1'b0;
      rsh_q     <= 1'b0;
      caps_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (bus.ps2_overflow) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.ps2_ready) begin
            byte_q  <= bus.ps2_data;
            nd_n_q  <= 1'b0;
            state_q <= S_POP;
          end
        end

        S_POP: begin
          nd_n_q <= 1'b1;
          if (byte_q == SC_EXT) begin
            // E0 after F0 is out of order: drop the whole partial sequence.
            if (brk_q) begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end else begin
              ext_q <= 1'b1;
            end
            state_q <= S_GAP;
          end else if (byte_q == SC_BRK) begin
            brk_q   <= 1'b1;
            state_q <= S_GAP;
          end else if (is_bad_byte(byte_q)) begin
            err_q   <= 1'b1;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            state_q <= S_GAP;
          end else begin
            code_q    <= byte_q;
            evt_ext_q <= ext_q;
            evt_brk_q <= brk_q;
            vld_q     <= 1'b1;
            state_q   <= S_EMIT;
          end
        end

        // Lets the FIFO's ready/data reflect the pop before we sample again.
        S_GAP: state_q <= S_IDLE;

        S_EMIT: begin
          if (bus.evt_ready) begin
            vld_q   <= 1'b0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            state_q <= S_GAP;
            if (!evt_brk_q) begin
              if (!is_rep) begin
                held_q   <= evt_key;
                held_v_q <= 1'b1;
                cnt_q    <= cnt_q + CNT_W'(1);
                if (!evt_ext_q && code_q == SC_CAPS) caps_q <= ~caps_q;
              end
              if (!evt_ext_q && code_q == SC_LSHIFT) lsh_q <= 1'b1;
              if (!evt_ext_q && code_q == SC_RSHIFT) rsh_q <= 1'b1;
            end else begin
              if (held_v_q && held_q == evt_key) held_v_q <= 1'b0;
              if (!evt_ext_q && code_q == SC_LSHIFT) lsh_q <= 1'b0;
              if (!evt_ext_q && code_q == SC_RSHIFT) rsh_q <= 1'b0;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ps2_nextdata_n = nd_n_q;
  assign bus.evt_valid      = vld_q;
  assign bus.evt_code       = code_q;
  assign bus.evt_ext        = evt_ext_q;
  assign bus.evt_break      = evt_brk_q;
  assign bus.evt_repeat     = is_rep;
  assign bus.shift_held     = lsh_q | rsh_q;
  assign bus.caps_lock      = caps_q;
  assign bus.key_count      = cnt_q;
  assign bus.err            = err_q;

endmodule
